// File: rtl/mem_wb_stage_if.sv
// Bundle of the EX/MEM handoff, data-memory read port and writeback/forwarding bus.
// master is the MEM/WB stage's view; slave is the surrounding pipeline and memory.
// No logic in here; timing and backpressure belong to the stage itself.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // EX/MEM -> stage
    logic              exmem_valid;
    logic              exmem_ready;
    logic [REG_W-1:0]  exmem_regd;
    logic              exmem_regwrite;
    logic              exmem_memtoreg;
    logic [DATA_W-1:0] exmem_alu_result;
    logic [1:0]        exmem_load_size;
    logic              exmem_load_unsigned;
    // stage <-> data memory
    logic              dmem_req;
    logic [DATA_W-1:0] dmem_addr;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    // stage -> register file / forwarding
    logic [REG_W-1:0]  mem_wb_regd;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_regwrite;
    logic              mem_err;

    modport master (
        input  exmem_valid, exmem_regd, exmem_regwrite, exmem_memtoreg,
               exmem_alu_result, exmem_load_size, exmem_load_unsigned,
               dmem_ready, dmem_rdata,
        output exmem_ready, dmem_req, dmem_addr,
               mem_wb_regd, mem_wb_data, mem_wb_regwrite, mem_err
    );

    modport slave (
        output exmem_valid, exmem_regd, exmem_regwrite, exmem_memtoreg,
               exmem_alu_result, exmem_load_size, exmem_load_unsigned,
               dmem_ready, dmem_rdata,
        input  exmem_ready, dmem_req, dmem_addr,
               mem_wb_regd, mem_wb_data, mem_wb_regwrite, mem_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: retires ALU results, runs a dmem read for loads, extends load data, drives writeback.
// Latency: ALU ops 1 edge after transfer; loads >= 2 edges (transfer, then the dmem_ready edge).
// Backpressure: exmem_ready only in IDLE; optional watchdog under `MEM_WB_TIMEOUT_EN`.
module mem_wb_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    mem_wb_stage_if.master bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [REG_W-1:0]  ld_regd_q, ld_regd_d;
    logic              ld_wr_q, ld_wr_d;        // load targets a real (non-$0) register
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q, ld_uns_d;
    logic [DATA_W-1:0] ld_addr_q, ld_addr_d;    // low two bits double as the lane select
    logic [REG_W-1:0]  wb_regd_q, wb_regd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_wr_q, wb_wr_d;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Pick the addressed lane and sign/zero extend; size 2'b11 behaves as a word.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] rd,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        lane,
                                                      input logic              uns);
        logic [15:0]       h;
        logic [7:0]        b;
        logic [DATA_W-1:0] r;
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (size)
            2'b01:   r = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            2'b10:   r = uns ? {{(DATA_W-8){1'b0}}, b}  : {{(DATA_W-8){b[7]}}, b};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign bus.exmem_ready     = (state_q == IDLE);
    assign bus.dmem_req        = (state_q == WAIT);
    assign bus.dmem_addr       = ld_addr_q;
    assign bus.mem_wb_regd     = wb_regd_q;
    assign bus.mem_wb_data     = wb_data_q;
    assign bus.mem_wb_regwrite = wb_wr_q;
`ifdef MEM_WB_TIMEOUT_EN
    assign bus.mem_err         = err_q;
`else
    assign bus.mem_err         = 1'b0;
`endif

    // Next state, load latches and writeback; writeback defaults to a bubble every cycle.
    always_comb begin
        state_d   = state_q;
        ld_regd_d = ld_regd_q;
        ld_wr_d   = ld_wr_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        ld_addr_d = ld_addr_q;
        wb_regd_d = '0;
        wb_data_d = '0;
        wb_wr_d   = 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.exmem_valid && !flush) begin
                    if (bus.exmem_memtoreg) begin
                        ld_regd_d = bus.exmem_regd;
                        ld_wr_d   = bus.exmem_regwrite && (bus.exmem_regd != '0);
                        ld_size_d = bus.exmem_load_size;
                        ld_uns_d  = bus.exmem_load_unsigned;
                        ld_addr_d = bus.exmem_alu_result;
                        state_d   = WAIT;
`ifdef MEM_WB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else if (bus.exmem_regwrite && (bus.exmem_regd != '0)) begin
                        wb_regd_d = bus.exmem_regd;
                        wb_data_d = bus.exmem_alu_result;
                        wb_wr_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
`ifdef MEM_WB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (bus.dmem_ready) begin
                    state_d = IDLE;
                    if (ld_wr_q) begin
                        wb_regd_d = ld_regd_q;
                        wb_data_d = load_extend(bus.dmem_rdata, ld_size_q, ld_addr_q[1:0], ld_uns_q);
                        wb_wr_d   = 1'b1;
                    end
                end else begin
`ifdef MEM_WB_TIMEOUT_EN
                    // Give up on the cycle the count would reach the limit.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers; reset wins over any in-flight load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ld_regd_q <= '0;
            ld_wr_q   <= 1'b0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
            ld_addr_q <= '0;
            wb_regd_q <= '0;
            wb_data_q <= '0;
            wb_wr_q   <= 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ld_regd_q <= ld_regd_d;
            ld_wr_q   <= ld_wr_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            ld_addr_q <= ld_addr_d;
            wb_regd_q <= wb_regd_d;
            wb_data_q <= wb_data_d;
            wb_wr_q   <= wb_wr_d;
`ifdef MEM_WB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: scoreboard of expected writebacks (register, data, cycle).
// Stimulus driven on the falling edge; outputs sampled 1 time unit after the rising edge.
// Watchdog bounds the run; timeout scenario runs only when MEM_WB_TIMEOUT_EN is defined.
module tb_mem_wb_stage;

    typedef struct {
        logic [4:0]  regd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mem_wb_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [4:0] regd, input logic [31:0] data, input int at);
        exp_t e;
        e.regd = regd;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic set_op(input logic [4:0] regd, input logic [31:0] alu, input logic rw,
                          input logic m2r, input logic [1:0] size, input logic uns);
        bus.exmem_valid         = 1'b1;
        bus.exmem_regd          = regd;
        bus.exmem_alu_result    = alu;
        bus.exmem_regwrite      = rw;
        bus.exmem_memtoreg      = m2r;
        bus.exmem_load_size     = size;
        bus.exmem_load_unsigned = uns;
    endtask

    // ALU op from IDLE; expected to appear one edge later unless it hits the $0 rule.
    task automatic alu_op(input logic [4:0] regd, input logic [31:0] alu, input logic rw);
        set_op(regd, alu, rw, 1'b0, 2'b00, 1'b0);
        if (rw && regd != 5'd0) push(regd, alu, cyc + 1);
        @(negedge clk);
        bus.exmem_valid = 1'b0;
    endtask

    // Load from IDLE with dmem_ready raised on the n_wait-th WAIT cycle.
    task automatic do_load(input logic [4:0] regd, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic rw, input logic [31:0] rdata,
                           input int n_wait, input logic [31:0] expv);
        set_op(regd, addr, rw, 1'b1, size, uns);
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        for (int i = 0; i < n_wait; i++) begin
            chk("wait_exmem_ready", {31'd0, bus.exmem_ready}, 32'd0);
            chk("wait_dmem_req", {31'd0, bus.dmem_req}, 32'd1);
            chk("wait_dmem_addr", bus.dmem_addr, addr);
            if (i == n_wait - 1) begin
                bus.dmem_ready = 1'b1;
                bus.dmem_rdata = rdata;
                if (rw && regd != 5'd0) push(regd, expv, cyc + 1);
            end
            @(negedge clk);
        end
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = $urandom;
        chk("load_back_idle", {31'd0, bus.exmem_ready}, 32'd1);
    endtask

    // Monitor: every writeback must match the scoreboard head; every other cycle is a clean bubble.
    always @(posedge clk) begin
        #1;
        if (bus.mem_wb_regwrite) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {27'd0, bus.mem_wb_regd}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_regd", {27'd0, bus.mem_wb_regd}, {27'd0, e.regd});
                chk("wb_data", bus.mem_wb_data, e.data);
                chk("wb_cycle", cyc, e.cyc);
            end
        end else begin
            chk("bubble_regd", {27'd0, bus.mem_wb_regd}, 32'd0);
            chk("bubble_data", bus.mem_wb_data, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got cycle %0d expected < 20000", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.exmem_valid = 1'b0;
        bus.exmem_regd = '0;
        bus.exmem_regwrite = 1'b0;
        bus.exmem_memtoreg = 1'b0;
        bus.exmem_alu_result = '0;
        bus.exmem_load_size = '0;
        bus.exmem_load_unsigned = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_exmem_ready", {31'd0, bus.exmem_ready}, 32'd1);
        chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ALU ops, including the $0 rule in both forms
        alu_op(5'd8, 32'h0000_1234, 1'b1);
        @(negedge clk);
        alu_op(5'd0, 32'hFFFF_FFFF, 1'b1);
        alu_op(5'd5, 32'hCAFE_F00D, 1'b0);
        alu_op(5'd31, 32'h8000_0001, 1'b1);
        alu_op(5'd1, 32'h0000_0002, 1'b1);

        // Byte signed lane 3, ready on the third WAIT cycle, ALU op queued behind it
        set_op(5'd9, 32'h1000_0003, 1'b1, 1'b1, 2'b10, 1'b0);
        @(negedge clk);
        set_op(5'd10, 32'h0000_00AA, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("q_exmem_ready", {31'd0, bus.exmem_ready}, 32'd0);
            chk("q_dmem_req", {31'd0, bus.dmem_req}, 32'd1);
            if (i == 2) begin
                bus.dmem_ready = 1'b1;
                bus.dmem_rdata = 32'h80FF_0011;
                push(5'd9, 32'hFFFF_FF80, cyc + 1);
                push(5'd10, 32'h0000_00AA, cyc + 2);
            end
            @(negedge clk);
        end
        bus.dmem_ready = 1'b0;
        chk("q_idle_ready", {31'd0, bus.exmem_ready}, 32'd1);
        @(negedge clk);
        bus.exmem_valid = 1'b0;

        // Extension patterns, minimum and longer latencies
        do_load(5'd11, 32'h2000_0002, 2'b01, 1'b1, 1'b1, 32'hBEEF_1234, 1, 32'h0000_BEEF);
        do_load(5'd12, 32'h2000_0002, 2'b01, 1'b0, 1'b1, 32'hBEEF_1234, 2, 32'hFFFF_BEEF);
        do_load(5'd13, 32'h2000_0001, 2'b01, 1'b0, 1'b1, 32'h1234_8001, 1, 32'hFFFF_8001);
        do_load(5'd14, 32'h2000_0001, 2'b10, 1'b1, 1'b1, 32'h1122_33C4, 1, 32'h0000_0033);
        do_load(5'd15, 32'h2000_0002, 2'b10, 1'b0, 1'b1, 32'h00F0_0000, 4, 32'hFFFF_FFF0);
        do_load(5'd16, 32'h2000_0000, 2'b10, 1'b1, 1'b1, 32'hFFFF_FF9C, 1, 32'h0000_009C);
        do_load(5'd17, 32'h2000_0001, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        do_load(5'd18, 32'h2000_0003, 2'b11, 1'b0, 1'b1, 32'h8765_4321, 2, 32'h8765_4321);
        do_load(5'd0, 32'h2000_0000, 2'b00, 1'b0, 1'b1, 32'h1111_1111, 1, 32'h0);
        do_load(5'd19, 32'h2000_0000, 2'b00, 1'b0, 1'b0, 32'h2222_2222, 1, 32'h0);

        // Flush in WAIT coincident with dmem_ready: no retirement
        set_op(5'd20, 32'h3000_0000, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        flush = 1'b1;
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        flush = 1'b0;
        bus.dmem_ready = 1'b0;
        chk("flush_wait_ready", {31'd0, bus.exmem_ready}, 32'd1);
        chk("flush_wait_req", {31'd0, bus.dmem_req}, 32'd0);

        // Flush in IDLE blocks the transfer
        set_op(5'd7, 32'h0000_0055, 1'b1, 1'b0, 2'b00, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.exmem_valid = 1'b0;
        chk("flush_idle_ready", {31'd0, bus.exmem_ready}, 32'd1);

        // dmem_ready in IDLE is ignored
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        chk("idle_ready_ignored", {31'd0, bus.dmem_req}, 32'd0);
        alu_op(5'd21, 32'h0BAD_F00D, 1'b1);

        // Reset mid-WAIT
        set_op(5'd22, 32'h4000_0000, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_exmem_ready", {31'd0, bus.exmem_ready}, 32'd1);
        chk("rstw_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rstw_regwrite", {31'd0, bus.mem_wb_regwrite}, 32'd0);
        chk("rstw_data", bus.mem_wb_data, 32'd0);
        chk("rstw_addr", bus.dmem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef MEM_WB_TIMEOUT_EN
        set_op(5'd23, 32'h5000_0000, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_dmem_req", {31'd0, bus.dmem_req}, 32'd1);
            chk("to_err_low", {31'd0, bus.mem_err}, 32'd0);
            @(negedge clk);
        end
        chk("to_err_set", {31'd0, bus.mem_err}, 32'd1);
        chk("to_req_drop", {31'd0, bus.dmem_req}, 32'd0);
        chk("to_idle", {31'd0, bus.exmem_ready}, 32'd1);
        @(negedge clk);
        chk("to_err_sticky", {31'd0, bus.mem_err}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("to_err_cleared", {31'd0, bus.mem_err}, 32'd0);
        @(negedge clk);
`else
        set_op(5'd23, 32'h5000_0000, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        repeat (10) begin
            chk("hold_dmem_req", {31'd0, bus.dmem_req}, 32'd1);
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("hold_req_drop", {31'd0, bus.dmem_req}, 32'd0);
        chk("hold_err_zero", {31'd0, bus.mem_err}, 32'd0);
`endif

        alu_op(5'd24, 32'h1357_9BDF, 1'b1);
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
